touch_uart_tx: RTL

TOUCH_UART_TX -- requirements
Module: touch_uart_tx

---
 rtl/touch_uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/touch_uart_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/touch_uart_pkg.sv
// Shared types and defaults for the touchscreen UART transmitter.
// Also provides the elaboration-time bit-period calculation.
package touch_uart_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD   = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Rounded clock cycles per bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter and a registered read port.
// rdata updates on the pop edge; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = rdata_q;
    assign level   = level_q;

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
        if (pop_ok)  rdata_q <= mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/touch_uart_tx.sv
// 8N1 serial transmitter feeding a touchscreen controller, fronted by a byte FIFO.
// Back-to-back queued bytes go out with no idle time between stop and start.
module touch_uart_tx
    import touch_uart_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int BAUD   = DEFAULT_BAUD,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   txd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int              DIV      = calc_div(CLK_HZ, BAUD);
    localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   DIV_LOAD = CW'(DIV - 1);

    tx_state_t               state_q, state_d;
    logic [CW-1:0]           baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic                    txd_q, txd_d;
    logic                    fifo_pop, fifo_push, fifo_full, fifo_empty, tick;
    logic [7:0]              fifo_rdata;
    logic [$clog2(DEPTH):0]  fifo_level;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign level     = fifo_level;
    assign txd       = txd_q;
    assign busy      = (state_q != IDLE) || (fifo_level != '0);
    assign tick      = (baud_q == '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The popped byte lands in fifo_rdata on the pop edge and stays put for the
    // whole start bit, so it is copied into the shifter when START ends.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = START;
                    baud_d   = DIV_LOAD;
                    txd_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    baud_d  = DIV_LOAD;
                    bit_d   = 3'd0;
                    shift_d = fifo_rdata;
                    txd_d   = fifo_rdata[0];
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_d = DIV_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[0], shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = START;
                        baud_d   = DIV_LOAD;
                        txd_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

endmodule
